// File: rtl/wb_port_arbiter_if.sv
// Bundle of the writeback arbiter's bus signals.
//   pipe_*      : in-order pipeline writeback token and payload
//   mc_*        : multi-cycle unit result offer and FIFO-ready back-pressure
//   pipe_hold   : asks the pipeline to skip issuing a writeback this cycle
//   rf_*        : registered register-file write port
//   err_collide : sticky flag, a pipeline write arrived during pipe_hold
//   fifo_count  : multi-cycle result FIFO occupancy
// Modports: master = the pipeline / execution-unit side, slave = the arbiter.
interface wb_port_arbiter_if #(
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            pipe_valid;
  logic            pipe_we;
  logic            pipe_aorf;
  logic [4:0]      pipe_rd;
  logic [31:0]     pipe_data;
  logic            mc_valid;
  logic            mc_ready;
  logic            mc_aorf;
  logic [4:0]      mc_rd;
  logic [31:0]     mc_data;
  logic            pipe_hold;
  logic            rf_we;
  logic            rf_aorf;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic            err_collide;
  logic [CntW-1:0] fifo_count;

  modport master (
    output pipe_valid, pipe_we, pipe_aorf, pipe_rd, pipe_data,
    output mc_valid, mc_aorf, mc_rd, mc_data,
    input  mc_ready, pipe_hold, rf_we, rf_aorf, rf_waddr, rf_wdata, err_collide, fifo_count
  );

  modport slave (
    input  pipe_valid, pipe_we, pipe_aorf, pipe_rd, pipe_data,
    input  mc_valid, mc_aorf, mc_rd, mc_data,
    output mc_ready, pipe_hold, rf_we, rf_aorf, rf_waddr, rf_wdata, err_collide, fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the pipeline writeback (fixed priority) and one
// multi-cycle execution unit whose results wait in a small FIFO. A starvation counter forces a
// one-cycle pipe_hold so a blocked FIFO head always drains.
// Ports:
//   CLK     : clock, all state on posedge
//   reset_n : asynchronous active-low reset
//   bus_io  : wb_port_arbiter_if.slave (pipe_*, mc_*, pipe_hold, rf_*, err_collide, fifo_count)
// Optional feature: define WB_ARB_BYPASS_EN to write an mc beat straight to the register file
// (latency 1) when the FIFO is empty and neither a pipeline write nor a hold is pending.
module wb_port_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic              CLK,
  input logic              reset_n,
  wb_port_arbiter_if.slave bus_io
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic        aorf;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic            hold_q, hold_d;
  logic            err_q, err_d;
  logic            rf_we_q, rf_we_d;
  entry_t          rf_q, rf_d;

  logic            pw, nonempty, full, accept, push, pop, src_valid;
  entry_t          src, mc_entry, pipe_entry;

  assign pw         = bus_io.pipe_valid & bus_io.pipe_we;
  assign nonempty   = (count_q != '0);
  assign full       = (count_q == CntW'(DEPTH));
  assign accept     = bus_io.mc_valid & ~full;
  assign mc_entry   = '{aorf: bus_io.mc_aorf, rd: bus_io.mc_rd, data: bus_io.mc_data};
  assign pipe_entry = '{aorf: bus_io.pipe_aorf, rd: bus_io.pipe_rd, data: bus_io.pipe_data};

`ifdef WB_ARB_BYPASS_EN
  logic bypass;
  // A bypassed beat goes straight to the write port and never occupies a FIFO slot.
  assign bypass = accept & ~nonempty & ~pw & ~hold_q;
  assign push   = accept & ~bypass;
`else
  assign push   = accept;
`endif

  // Grant: forced drain during hold, then pipeline, then FIFO head.
  always_comb begin
    pop       = 1'b0;
    src_valid = 1'b0;
    src       = '0;
    err_d     = err_q;
    if (hold_q && nonempty) begin
      pop       = 1'b1;
      src       = mem_q[rd_ptr_q];
      src_valid = 1'b1;
      if (pw) err_d = 1'b1;  // the pipeline write is dropped
    end else if (pw) begin
      src       = pipe_entry;
      src_valid = 1'b1;
    end else if (nonempty) begin
      pop       = 1'b1;
      src       = mem_q[rd_ptr_q];
      src_valid = 1'b1;
`ifdef WB_ARB_BYPASS_EN
    end else if (bypass) begin
      src       = mc_entry;
      src_valid = 1'b1;
`endif
    end
  end

  always_comb begin
    // Integer r0 is hard-wired: consume the source but suppress the strobe.
    rf_we_d  = src_valid & (src.aorf | (src.rd != 5'd0));
    rf_d     = src_valid ? src : rf_q;
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push) - CntW'(pop);
    if (pop || !nonempty) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != 8'hFF) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
    // Without a pop this cycle the FIFO stays non-empty, so the hold always has a head to drain.
    hold_d = nonempty & ~pop & (wait_cnt_q == 8'(STARVE_LIMIT));
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_cnt_q <= '0;
      hold_q     <= 1'b0;
      err_q      <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_q       <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wait_cnt_q <= wait_cnt_d;
      hold_q     <= hold_d;
      err_q      <= err_d;
      rf_we_q    <= rf_we_d;
      rf_q       <= rf_d;
    end
  end

  // Storage needs no reset; the pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= mc_entry;
  end

  assign bus_io.mc_ready    = ~full;
  assign bus_io.pipe_hold   = hold_q;
  assign bus_io.rf_we       = rf_we_q;
  assign bus_io.rf_aorf     = rf_q.aorf;
  assign bus_io.rf_waddr    = rf_q.rd;
  assign bus_io.rf_wdata    = rf_q.data;
  assign bus_io.err_collide = err_q;
  assign bus_io.fifo_count  = count_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  logic CLK = 1'b0;
  logic reset_n = 1'b0;
  always #5 CLK = ~CLK;

  wb_port_arbiter_if #(.DEPTH(2)) bus ();

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus_io  (bus)
  );

  typedef struct packed {
    logic        aorf;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        pv;
    logic        we;
    logic        aorf;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exp_we;
    logic        exp_aorf;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  // One in-order scoreboard per register file.
  wr_t  int_q[$];
  wr_t  flt_q[$];
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[6];

  int   pn, mi, holds, first_hold, acc2;
  logic prev_pw, hold_now, pw_now, mc_take;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic aorf, input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e = '{aorf: aorf, rd: rd, data: data};
    if (aorf) flt_q.push_back(e);
    else      int_q.push_back(e);
  endtask

  task automatic step();
    wr_t e;
    @(posedge CLK);
    #1;
    if (bus.rf_we === 1'b1) begin
      if ((bus.rf_aorf ? flt_q.size() : int_q.size()) == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got write aorf=%0d waddr=%0d wdata=%h expected none",
                 bus.rf_aorf, bus.rf_waddr, bus.rf_wdata);
      end else begin
        e = bus.rf_aorf ? flt_q.pop_front() : int_q.pop_front();
        check("sb_write", {bus.rf_aorf, bus.rf_waddr, bus.rf_wdata}, e);
      end
    end
  endtask

  task automatic drive_pipe(input logic pv, input logic we, input logic aorf, input logic [4:0] rd,
                            input logic [31:0] data);
    bus.pipe_valid = pv;
    bus.pipe_we    = we;
    bus.pipe_aorf  = aorf;
    bus.pipe_rd    = rd;
    bus.pipe_data  = data;
  endtask

  task automatic mc_idle();
    bus.mc_valid = 1'b0;
    bus.mc_aorf  = 1'b0;
    bus.mc_rd    = 5'd0;
    bus.mc_data  = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 5'd0,  32'h12345678, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 5'd0,  32'h3F800000, 1'b1, 1'b1, 5'd0,  32'h3F800000};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 1'b1, 5'd31, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 5'd7,  32'h77777777, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 5'd8,  32'h88888888, 1'b0, 1'b0, 5'd0,  32'h0};

    drive_pipe(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    mc_idle();

    // Power-on reset.
    repeat (2) @(posedge CLK);
    #3 reset_n = 1'b1;
    step();
    check("rst_rf_we",    bus.rf_we, 0);
    check("rst_rf_fields", {bus.rf_aorf, bus.rf_waddr, bus.rf_wdata}, 0);
    check("rst_hold",     bus.pipe_hold, 0);
    check("rst_err",      bus.err_collide, 0);
    check("rst_count",    bus.fifo_count, 0);
    check("rst_mc_ready", bus.mc_ready, 1);

    // Pipeline-only vectors.
    for (int i = 0; i < 6; i++) begin
      drive_pipe(vecs[i].pv, vecs[i].we, vecs[i].aorf, vecs[i].rd, vecs[i].data);
      if (vecs[i].exp_we) push_exp(vecs[i].exp_aorf, vecs[i].exp_waddr, vecs[i].exp_wdata);
      step();
      check($sformatf("vec%0d_we", i), bus.rf_we, vecs[i].exp_we);
    end
    drive_pipe(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    // Idle cycles keep the last written fields.
    check("idle_hold_fields", {bus.rf_aorf, bus.rf_waddr, bus.rf_wdata}, {1'b1, 5'd31, 32'hCAFEF00D});

    // Multi-cycle only: two-cycle latency through the FIFO.
    bus.mc_valid = 1'b1; bus.mc_aorf = 1'b1; bus.mc_rd = 5'd3; bus.mc_data = 32'h3F800000;
    check("mc_ready_empty", bus.mc_ready, 1);
    push_exp(1'b1, 5'd3, 32'h3F800000);
    step();
    mc_idle();
    check("mc_t1_count", bus.fifo_count, 1);
    check("mc_t1_we",    bus.rf_we, 0);
    step();
    check("mc_t2_count", bus.fifo_count, 0);
    check("mc_t2_we",    bus.rf_we, 1);

    // Multi-cycle integer r0: consumed, never written.
    bus.mc_valid = 1'b1; bus.mc_aorf = 1'b0; bus.mc_rd = 5'd0; bus.mc_data = 32'h55555555;
    step();
    mc_idle();
    check("mc_r0_t1_count", bus.fifo_count, 1);
    step();
    check("mc_r0_t2_count", bus.fifo_count, 0);
    check("mc_r0_t2_we",    bus.rf_we, 0);

    // Priority and fill: pipeline writes every cycle except during pipe_hold.
    pn = 0; mi = 0; holds = 0; first_hold = -1; acc2 = -1; prev_pw = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (prev_pw) check("fill_prio", {bus.rf_we, bus.rf_aorf}, 2'b10);
      hold_now = bus.pipe_hold;
      if (hold_now) begin
        holds++;
        if (first_hold < 0) first_hold = cyc;
      end
      pw_now = (cyc < 24) && !hold_now;
      if (pw_now) begin
        drive_pipe(1'b1, 1'b1, 1'b0, 5'((pn % 31) + 1), 32'h1000 + pn);
        push_exp(1'b0, 5'((pn % 31) + 1), 32'h1000 + pn);
        pn++;
      end else begin
        drive_pipe(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      end
      mc_take = 1'b0;
      if (mi < 3) begin
        bus.mc_valid = 1'b1; bus.mc_aorf = 1'b1;
        bus.mc_rd = 5'(10 + mi); bus.mc_data = 32'h2000 + mi;
        if (cyc == 2) begin
          check("fill_ready_full", bus.mc_ready, 0);
          check("fill_count_full", bus.fifo_count, 2);
        end
        if (bus.mc_ready) begin
          push_exp(1'b1, 5'(10 + mi), 32'h2000 + mi);
          if (mi == 2) acc2 = cyc;
          mc_take = 1'b1;
        end
      end else begin
        mc_idle();
      end
      prev_pw = pw_now;
      step();
      if (mc_take) mi++;
    end
    check("fill_first_hold", first_hold, 10);
    check("fill_hold_count", holds, 2);
    check("fill_third_accept", acc2, 11);
    check("fill_drained", bus.fifo_count, 0);
    check("fill_no_collide", bus.err_collide, 0);

    // Collision: one starved entry, pipeline keeps writing through the hold.
    for (int cyc = 0; cyc < 20; cyc++) begin
      hold_now = bus.pipe_hold;
      check($sformatf("coll_hold_c%0d", cyc), hold_now, (cyc == 10));
      drive_pipe(1'b1, 1'b1, 1'b0, 5'(20 + (cyc % 8)), 32'h3000 + cyc);
      if (!hold_now) push_exp(1'b0, 5'(20 + (cyc % 8)), 32'h3000 + cyc);
      if (cyc == 0) begin
        bus.mc_valid = 1'b1; bus.mc_aorf = 1'b1; bus.mc_rd = 5'd17; bus.mc_data = 32'h40000000;
        push_exp(1'b1, 5'd17, 32'h40000000);
      end else begin
        mc_idle();
      end
      step();
    end
    drive_pipe(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    check("coll_err_set", bus.err_collide, 1);
    repeat (5) step();
    check("coll_err_sticky", bus.err_collide, 1);

    // Asynchronous reset with a full FIFO and a write in flight.
    drive_pipe(1'b1, 1'b1, 1'b0, 5'd2, 32'hA2);
    push_exp(1'b0, 5'd2, 32'hA2);
    bus.mc_valid = 1'b1; bus.mc_aorf = 1'b1; bus.mc_rd = 5'd4; bus.mc_data = 32'hB4;
    step();
    drive_pipe(1'b1, 1'b1, 1'b0, 5'd3, 32'hA3);
    push_exp(1'b0, 5'd3, 32'hA3);
    bus.mc_rd = 5'd6; bus.mc_data = 32'hB6;
    step();
    drive_pipe(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    mc_idle();
    check("arst_pre_we",    bus.rf_we, 1);
    check("arst_pre_count", bus.fifo_count, 2);
    #2 reset_n = 1'b0;
    #1;
    check("arst_we",    bus.rf_we, 0);
    check("arst_count", bus.fifo_count, 0);
    check("arst_err",   bus.err_collide, 0);
    #3 reset_n = 1'b1;
    step();
    check("arst_mc_ready", bus.mc_ready, 1);
    check("arst_idle_we",  bus.rf_we, 0);
    drive_pipe(1'b1, 1'b1, 1'b0, 5'd9, 32'h900D);
    push_exp(1'b0, 5'd9, 32'h900D);
    step();
    drive_pipe(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("arst_post_we", bus.rf_we, 1);
    repeat (3) step();

    check("sb_int_drained", int_q.size(), 0);
    check("sb_flt_drained", flt_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
